// File: rtl/mux_scanner.sv
// Select-line driver and capture stage for a 4-to-1 mux.
// Steps a,b,c,d, samples q after a settle time, offers a 4-bit word.
module mux_scanner #(
   parameter int unsigned SETTLE = 1
) (
   input  logic       i_clk,
   input  logic       i_reset,
   input  logic       i_start,
   input  logic       i_mux_q,
   output logic       o_s0,
   output logic       o_s1,
   output logic [3:0] o_word,
   output logic       o_valid,
   input  logic       i_ready,
   output logic       o_busy
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      HOLD = 2'd2
   } state_t;

   localparam logic [3:0] LP_SETTLE = 4'(SETTLE);

   state_t     r_state;
   state_t     w_state_nx;
   logic [3:0] r_cnt;
   logic [3:0] w_cnt_nx;
   logic [1:0] r_k;
   logic [1:0] w_k_nx;
   logic [1:0] r_sel;
   logic [1:0] w_sel_nx;
   logic [3:0] r_shadow;
   logic [3:0] w_shadow_nx;
   logic [3:0] r_word;
   logic [3:0] w_word_nx;
   logic       r_valid;
   logic       w_valid_nx;

   logic w_last;
   logic w_done;
   logic w_accept;

   assign w_last   = (r_cnt == 4'd0);
   assign w_done   = w_last && (r_k == 2'd3);
   assign w_accept = r_valid && i_ready;

   always_ff @(posedge i_clk) begin
      if (i_reset) r_state <= IDLE;
      else         r_state <= w_state_nx;
   end

   always_comb begin
      w_state_nx = r_state;
      case (r_state)
         IDLE: if (i_start) w_state_nx = SCAN;
         SCAN: if (w_done) w_state_nx = HOLD;
         HOLD: begin
            if (w_accept) w_state_nx = i_start ? SCAN : IDLE;
         end
         default: w_state_nx = IDLE;
      endcase
   end

   // Bit index 3-k equals the select code, so a lands in word[3].
   always_comb begin
      w_cnt_nx    = r_cnt;
      w_k_nx      = r_k;
      w_sel_nx    = r_sel;
      w_shadow_nx = r_shadow;
      w_word_nx   = r_word;
      w_valid_nx  = r_valid;
      case (r_state)
         IDLE: begin
            if (i_start) begin
               w_cnt_nx = LP_SETTLE;
               w_k_nx   = 2'd0;
               w_sel_nx = 2'd3;
            end
         end
         SCAN: begin
            if (!w_last) begin
               w_cnt_nx = r_cnt - 4'd1;
            end else if (r_k != 2'd3) begin
               w_shadow_nx[2'd3 - r_k] = i_mux_q;
               w_k_nx   = r_k + 2'd1;
               w_sel_nx = r_sel - 2'd1;
               w_cnt_nx = LP_SETTLE;
            end else begin
               w_word_nx  = {r_shadow[3:1], i_mux_q};
               w_valid_nx = 1'b1;
               w_sel_nx   = 2'd0;
               w_k_nx     = 2'd0;
               w_cnt_nx   = 4'd0;
            end
         end
         HOLD: begin
            if (w_accept) begin
               w_valid_nx = 1'b0;
               if (i_start) begin
                  w_cnt_nx = LP_SETTLE;
                  w_k_nx   = 2'd0;
                  w_sel_nx = 2'd3;
               end
            end
         end
         default: begin
            w_valid_nx = 1'b0;
            w_sel_nx   = 2'd0;
         end
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_cnt    <= 4'd0;
         r_k      <= 2'd0;
         r_sel    <= 2'd0;
         r_shadow <= 4'd0;
         r_word   <= 4'd0;
         r_valid  <= 1'b0;
      end else begin
         r_cnt    <= w_cnt_nx;
         r_k      <= w_k_nx;
         r_sel    <= w_sel_nx;
         r_shadow <= w_shadow_nx;
         r_word   <= w_word_nx;
         r_valid  <= w_valid_nx;
      end
   end

   assign o_s1    = r_sel[1];
   assign o_s0    = r_sel[0];
   assign o_word  = r_word;
   assign o_valid = r_valid;
   assign o_busy  = (r_state != IDLE);

endmodule
